// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/flush unit.
// Contents:
//   hfu_state_e  - control FSM states
//   CW_*         - bit positions of fields in the decoded control word
//   CNT_W        - width of the shared stall/flush down-counter
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MD_WAIT    = 2'd2,
        REDIRECT   = 2'd3
    } hfu_state_e;

    // Decoded control-word field positions (11-bit default word)
    localparam int CW_REGWRITE = 0;
    localparam int CW_MEMREAD  = 1;
    localparam int CW_MEMWRITE = 2;
    localparam int CW_MEMTOREG = 3;
    localparam int CW_ALUSRC   = 4;
    localparam int CW_REGDST   = 5;
    localparam int CW_ALUOP_LO = 6;
    localparam int CW_ALUOP_HI = 8;
    localparam int CW_BRANCH   = 9;
    localparam int CW_JUMP     = 10;

    // Counter covers latencies up to 15
    localparam int CNT_W = $clog2(16);

endpackage

// File: rtl/stall_counter.sv
// Loadable down-counter with zero flag, shared by the multi-cycle wait
// and the redirect flush sequences.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   load_i         - load load_val_i (has priority over decrement)
//   load_val_i     - value to load
//   dec_i          - decrement request; saturates at zero (never wraps)
//   zero_o         - count is zero
module stall_counter
    import hazard_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_flush_unit.sv
// Pipeline hazard and flush control between ID and EX.
// Handles load-use stalls, branch/jump redirect flushes and multi-cycle
// (mult/div) EX occupancy, and registers the control word entering EX.
// Ports:
//   clk, reset             - clock, asynchronous active-high reset
//   id_cw, id_rs, id_rt    - ID control word and source registers
//   idex_memread, idex_rt  - EX-stage load flag and destination
//   redirect               - taken branch / jump resolved in ID
//   md_start               - ID holds a multi-cycle op
//   pc_write, ifid_write   - PC / IF-ID register write enables (comb)
//   ifid_flush             - IF-ID flush (comb)
//   ex_cw                  - registered control word into EX (bubble = 0)
//   busy                   - FSM is not in RUN (comb)
module hazard_flush_unit
    import hazard_pkg::*;
#(
    parameter int CW_WIDTH     = 11,
    parameter int REG_AW       = 5,
    parameter int MD_LATENCY   = 4,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CW_WIDTH-1:0] id_cw,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic                idex_memread,
    input  logic [REG_AW-1:0]   idex_rt,
    input  logic                redirect,
    input  logic                md_start,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                ifid_flush,
    output logic [CW_WIDTH-1:0] ex_cw,
    output logic                busy
);

    localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LATENCY - 1);
    // The first flush cycle happens in RUN, so REDIRECT covers the rest
    localparam logic [CNT_W-1:0] FL_LOAD =
        (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;

    hfu_state_e            state_q;
    hfu_state_e            state_d;
    logic [CW_WIDTH-1:0]   ex_cw_q;
    logic [CW_WIDTH-1:0]   ex_cw_d;

    logic                  load_use;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_dec;
    logic                  cnt_zero;

    // Register 0 is hardwired, so a match on it is never a real hazard
    assign load_use = idex_memread && (idex_rt != '0) &&
                      ((idex_rt == id_rs) || (idex_rt == id_rt));

    stall_counter #(
        .W (CNT_W)
    ) u_stall_counter (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        ex_cw_d      = id_cw;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            // LOAD_STALL resolves redirect/md_start exactly as RUN does;
            // only the load-use check is skipped there.
            RUN, LOAD_STALL: begin
                if ((state_q == RUN) && load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    ex_cw_d    = '0;
                    state_d    = LOAD_STALL;
                end else if (redirect) begin
                    ifid_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        cnt_load     = 1'b1;
                        cnt_load_val = FL_LOAD;
                        state_d      = REDIRECT;
                    end else begin
                        state_d = RUN;
                    end
                end else if (md_start) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = MD_LOAD;
                    state_d      = MD_WAIT;
                end else begin
                    state_d = RUN;
                end
            end
            MD_WAIT: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ex_cw_d    = '0;
                if (cnt_zero) begin
                    state_d = RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            REDIRECT: begin
                ifid_flush = 1'b1;
                ex_cw_d    = '0;
                if (cnt_zero) begin
                    state_d = RUN;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        busy = (state_q != RUN);

        // Reset holds the front end frozen and flushed
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            busy       = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            ex_cw_q <= '0;
        end else begin
            state_q <= state_d;
            ex_cw_q <= ex_cw_d;
        end
    end

    assign ex_cw = ex_cw_q;

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Self-checking bench for hazard_flush_unit (MD_LATENCY=4, FLUSH_CYCLES=3).
// A cycle-level model tracks remaining frozen/flush cycles and whether the
// previous cycle was a load-use bubble; directed vectors add literal checks.
module tb_hazard_flush_unit;

    localparam int CWW = 11;
    localparam int AW  = 5;
    localparam int MDL = 4;
    localparam int FLC = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [CWW-1:0] id_cw;
    logic [AW-1:0]  id_rs;
    logic [AW-1:0]  id_rt;
    logic           idex_memread;
    logic [AW-1:0]  idex_rt;
    logic           redirect;
    logic           md_start;
    logic           pc_write;
    logic           ifid_write;
    logic           ifid_flush;
    logic [CWW-1:0] ex_cw;
    logic           busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    hazard_flush_unit #(
        .CW_WIDTH     (CWW),
        .REG_AW       (AW),
        .MD_LATENCY   (MDL),
        .FLUSH_CYCLES (FLC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_cw        (id_cw),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .redirect     (redirect),
        .md_start     (md_start),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .ex_cw        (ex_cw),
        .busy         (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             md_left    = 0;   // frozen cycles still owed to a mult/div
    int             fl_left    = 0;   // extra flush cycles still owed
    bit             post_stall = 0;   // previous cycle was a load-use bubble
    logic [CWW-1:0] exp_ex     = '0;
    int             n_md       = 0;
    int             n_fl       = 0;
    bit             n_post     = 0;
    logic [CWW-1:0] n_ex       = '0;

    always @(negedge clk) begin
        bit e_pc, e_ifw, e_fl, e_busy, hazard;
        hazard = idex_memread && (idex_rt != 0) &&
                 ((idex_rt == id_rs) || (idex_rt == id_rt));
        n_md = 0; n_fl = 0; n_post = 0; n_ex = '0;
        if (reset) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_busy = 0;
        end else if (md_left > 0) begin
            e_pc = 0; e_ifw = 0; e_fl = 0; e_busy = 1;
            n_md = md_left - 1;
        end else if (fl_left > 0) begin
            e_pc = 1; e_ifw = 1; e_fl = 1; e_busy = 1;
            n_fl = fl_left - 1;
        end else begin
            e_busy = post_stall;
            e_pc = 1; e_ifw = 1; e_fl = 0;
            if (!post_stall && hazard) begin
                e_pc = 0; e_ifw = 0;
                n_post = 1;
            end else if (redirect) begin
                e_fl = 1;
                n_ex = id_cw;
                n_fl = FLC - 1;
            end else if (md_start) begin
                n_ex = id_cw;
                n_md = MDL;
            end else begin
                n_ex = id_cw;
            end
        end
        chk("model_pc_write",   int'(pc_write),   int'(e_pc));
        chk("model_ifid_write", int'(ifid_write), int'(e_ifw));
        chk("model_ifid_flush", int'(ifid_flush), int'(e_fl));
        chk("model_busy",       int'(busy),       int'(e_busy));
        chk("model_ex_cw",      int'(ex_cw),      int'(exp_ex));
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            md_left <= 0; fl_left <= 0; post_stall <= 0; exp_ex <= '0;
        end else begin
            md_left <= n_md; fl_left <= n_fl; post_stall <= n_post; exp_ex <= n_ex;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic mr, input logic [AW-1:0] irt,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic rd, input logic md, input logic [CWW-1:0] cw);
        idex_memread = mr;
        idex_rt      = irt;
        id_rs        = rs;
        id_rt        = rt;
        redirect     = rd;
        md_start     = md;
        id_cw        = cw;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, '0);
        step(); step();
        chk("rst_pc_write",   int'(pc_write),   0);
        chk("rst_ifid_write", int'(ifid_write), 0);
        chk("rst_ifid_flush", int'(ifid_flush), 1);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_ex_cw",      int'(ex_cw),      0);
        reset = 1'b0;

        // Load-use on rs
        drive(1, 8, 8, 3, 0, 0, 11'h155);
        chk("lu_pc_write",   int'(pc_write),   0);
        chk("lu_ifid_write", int'(ifid_write), 0);
        chk("lu_ifid_flush", int'(ifid_flush), 0);
        step();
        chk("lu_bubble", int'(ex_cw), 0);
        chk("lu_busy",   int'(busy),  1);
        drive(0, 8, 8, 3, 0, 0, 11'h155);
        chk("lu_resume_pc", int'(pc_write), 1);
        step();
        chk("lu_issue", int'(ex_cw), 'h155);
        chk("lu_done_busy", int'(busy), 0);

        // Zero-register match must not stall; plain match without load neither
        drive(1, 0, 0, 0, 0, 0, 11'h0AA);
        chk("zero_pc_write", int'(pc_write), 1);
        chk("zero_busy",     int'(busy),     0);
        step();
        chk("zero_ex_cw", int'(ex_cw), 'h0AA);
        drive(0, 8, 8, 8, 0, 0, 11'h001);
        chk("noload_pc_write", int'(pc_write), 1);
        step();

        // Multi-cycle op
        drive(0, 0, 0, 0, 0, 1, 11'h123);
        chk("md_issue_pc", int'(pc_write), 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 11'h7FF);
        chk("md_issue_ex", int'(ex_cw),    'h123);
        chk("md_w1_pc",    int'(pc_write), 0);
        chk("md_w1_busy",  int'(busy),     1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("md_wait_pc", int'(pc_write), 0);
            chk("md_wait_ex", int'(ex_cw),    0);
        end
        step();
        chk("md_after_pc",   int'(pc_write), 1);
        chk("md_after_busy", int'(busy),     0);
        chk("md_after_ex",   int'(ex_cw),    0);
        step();
        chk("md_next_ex", int'(ex_cw), 'h7FF);

        // Redirect, three flush cycles
        drive(0, 0, 0, 0, 1, 0, 11'h0F0);
        chk("rd_f1_flush", int'(ifid_flush), 1);
        chk("rd_f1_busy",  int'(busy),       0);
        step();
        drive(0, 0, 0, 0, 0, 0, 11'h111);
        chk("rd_f2_flush", int'(ifid_flush), 1);
        chk("rd_f2_busy",  int'(busy),       1);
        chk("rd_pass_ex",  int'(ex_cw),      'h0F0);
        step();
        chk("rd_f3_flush", int'(ifid_flush), 1);
        chk("rd_f3_busy",  int'(busy),       1);
        chk("rd_f3_ex",    int'(ex_cw),      0);
        step();
        chk("rd_end_flush", int'(ifid_flush), 0);
        chk("rd_end_busy",  int'(busy),       0);
        step();
        chk("rd_next_ex", int'(ex_cw), 'h111);

        // Load-use and redirect together: stall wins, redirect follows
        drive(1, 9, 2, 9, 1, 0, 11'h2AA);
        chk("both_pc",    int'(pc_write),   0);
        chk("both_flush", int'(ifid_flush), 0);
        step();
        drive(0, 9, 2, 9, 1, 0, 11'h2AA);
        chk("both_ls_ex",    int'(ex_cw),      0);
        chk("both_ls_flush", int'(ifid_flush), 1);
        chk("both_ls_busy",  int'(busy),       1);
        step();
        drive(0, 0, 0, 0, 0, 0, 11'h000);
        chk("both_rd_ex",    int'(ex_cw),      'h2AA);
        chk("both_rd_flush", int'(ifid_flush), 1);
        step();
        chk("both_rd2_flush", int'(ifid_flush), 1);
        step();
        chk("both_end_flush", int'(ifid_flush), 0);
        chk("both_end_busy",  int'(busy),       0);

        // Reset in the second MD_WAIT cycle
        drive(0, 0, 0, 0, 0, 1, 11'h3C3);
        step();
        drive(0, 0, 0, 0, 0, 0, 11'h044);
        step();
        chk("mdrst_busy_before", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mdrst_ex_cw", int'(ex_cw),      0);
        chk("mdrst_busy",  int'(busy),       0);
        chk("mdrst_flush", int'(ifid_flush), 1);
        step();
        reset = 1'b0;
        #1;
        chk("mdrst_post_pc",   int'(pc_write), 1);
        chk("mdrst_post_busy", int'(busy),     0);
        step();
        chk("mdrst_post_ex", int'(ex_cw), 'h044);

        // Mixed traffic with small register numbers so hazards recur
        for (int i = 0; i < 120; i++) begin
            drive(logic'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 3)),
                  AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                  logic'($urandom_range(0, 6) == 0), logic'($urandom_range(0, 6) == 0),
                  CWW'($urandom));
            step();
        end

        drive(0, 0, 0, 0, 0, 0, '0);
        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
